// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and FSM state encoding for the 1x3 router
package router_pkg;

    localparam int ADDR_W          = 2;
    localparam int NUM_CH          = 3;
    localparam int TIMEOUT_DEFAULT = 30;

    localparam logic [ADDR_W-1:0] ADDR_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS    = 3'd0,
        ST_LOAD_FIRST_DATA   = 3'd1,
        ST_LOAD_DATA         = 3'd2,
        ST_WAIT_TILL_EMPTY   = 3'd3,
        ST_FIFO_FULL_STATE   = 3'd4,
        ST_LOAD_AFTER_FULL   = 3'd5,
        ST_LOAD_PARITY       = 3'd6,
        ST_CHECK_PARITY_ERR  = 3'd7
    } router_fsm_state_e;

endpackage

// File: rtl/router_timeout_ctr.sv
// rtl/router_timeout_ctr.sv - per-channel read-timeout watchdog with one-cycle soft reset
module router_timeout_ctr #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_rst
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_rst;

    // A read on the terminal edge outranks the timeout, so no pulse is raised.
    always_ff @(posedge clk) begin
        if (rst || !vld || rd) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b1;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_soft_rst <= 1'b0;
        end
    end

    assign soft_rst = r_soft_rst;

endmodule

// File: rtl/router_sync_ctrl.sv
// rtl/router_sync_ctrl.sv - address latch, write steering, full mux and watchdogs for the router outputs
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              detect_addr,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              full_0,
    input  logic              full_1,
    input  logic              full_2,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              soft_rst_0,
    output logic              soft_rst_1,
    output logic              soft_rst_2
);

    logic [ADDR_W-1:0] r_addr;
    logic [NUM_CH-1:0] w_write_enb;
    logic              w_fifo_full;
    logic [NUM_CH-1:0] w_vld;
    logic [NUM_CH-1:0] w_rd;
    logic [NUM_CH-1:0] w_soft_rst;

    // Soft resets deliberately leave the address alone; only decode reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= ADDR_NONE;
        end else if (detect_addr) begin
            r_addr <= data_in;
        end
    end

    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        case (r_addr)
            2'd0: begin
                w_write_enb[0] = write_enb_reg;
                w_fifo_full    = full_0;
            end
            2'd1: begin
                w_write_enb[1] = write_enb_reg;
                w_fifo_full    = full_1;
            end
            2'd2: begin
                w_write_enb[2] = write_enb_reg;
                w_fifo_full    = full_2;
            end
            default: begin
                w_write_enb = '0;
                w_fifo_full = 1'b0;
            end
        endcase
    end

    assign w_vld = ~{empty_2, empty_1, empty_0};
    assign w_rd  = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_wdog (
            .clk      (clk),
            .rst      (rst),
            .vld      (w_vld[g]),
            .rd       (w_rd[g]),
            .soft_rst (w_soft_rst[g])
        );
    end

    assign write_enb  = w_write_enb;
    assign fifo_full  = w_fifo_full;
    assign vld_out_0  = w_vld[0];
    assign vld_out_1  = w_vld[1];
    assign vld_out_2  = w_vld[2];
    assign soft_rst_0 = w_soft_rst[0];
    assign soft_rst_1 = w_soft_rst[1];
    assign soft_rst_2 = w_soft_rst[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// tb/tb_router_sync_ctrl.sv - randomized and directed self-checking bench for router_sync_ctrl
module tb_router_sync_ctrl;

    localparam int TMO = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       detect_addr;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] rd;
    logic [2:0] em;
    logic [2:0] fl;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_0, vld_1, vld_2;
    logic       srst_0, srst_1, srst_2;

    int total = 0;
    int bad   = 0;

    // reference state: selected channel (3 = none) and idle-valid edges since last clear
    int m_addr;
    int m_idle [3];
    bit m_pulse[3];

    always #5 clk = ~clk;

    router_sync_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .detect_addr   (detect_addr),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (rd[0]),
        .read_enb_1    (rd[1]),
        .read_enb_2    (rd[2]),
        .empty_0       (em[0]),
        .empty_1       (em[1]),
        .empty_2       (em[2]),
        .full_0        (fl[0]),
        .full_1        (fl[1]),
        .full_2        (fl[2]),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_0),
        .vld_out_1     (vld_1),
        .vld_out_2     (vld_2),
        .soft_rst_0    (srst_0),
        .soft_rst_1    (srst_1),
        .soft_rst_2    (srst_2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic quiet();
        rst = 1'b0; detect_addr = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
        rd = 3'b000; em = 3'b111; fl = 3'b000;
    endtask

    // Inputs are applied just after a falling edge; outputs are checked 1ns later, then the model advances on the rising edge.
    task automatic step();
        logic [2:0] exp_we;
        logic       exp_ff;
        #1;
        exp_we = (write_enb_reg && m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
        exp_ff = (m_addr < 3) ? fl[m_addr] : 1'b0;
        check_val("write_enb", {29'd0, write_enb}, {29'd0, exp_we});
        check_val("fifo_full", {31'd0, fifo_full}, {31'd0, exp_ff});
        check_val("vld_out", {29'd0, vld_2, vld_1, vld_0}, {29'd0, ~em});
        check_val("soft_rst", {29'd0, srst_2, srst_1, srst_0},
                  {29'd0, m_pulse[2], m_pulse[1], m_pulse[0]});
        @(posedge clk);
        if (rst) m_addr = 3;
        else if (detect_addr) m_addr = int'(data_in);
        for (int n = 0; n < 3; n++) begin
            m_pulse[n] = 1'b0;
            if (rst || em[n] || rd[n]) begin
                m_idle[n] = 0;
            end else begin
                m_idle[n]++;
                if (m_idle[n] == TMO) begin
                    m_pulse[n] = 1'b1;
                    m_idle[n]  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int p_rd, p_em;
        quiet();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_addr = 3;
        for (int n = 0; n < 3; n++) begin m_idle[n] = 0; m_pulse[n] = 1'b0; end

        // reset state: no channel selected even with a write request and all FIFOs full
        rst = 1'b0; write_enb_reg = 1'b1; fl = 3'b111;
        step();

        // address latch, full mux ignores unaddressed channels
        quiet(); detect_addr = 1'b1; data_in = 2'b01; step();
        quiet(); write_enb_reg = 1'b1; step();
        fl = 3'b010; step();
        for (int i = 0; i < 4; i++) begin fl = {1'(i), 1'b1, 1'(~i)}; step(); end
        fl = 3'b101; step();

        // invalid address
        quiet(); detect_addr = 1'b1; data_in = 2'b11; write_enb_reg = 1'b1; fl = 3'b111; step();
        detect_addr = 1'b0; step();

        // same-cycle update uses the old address
        quiet(); detect_addr = 1'b1; data_in = 2'b00; step();
        detect_addr = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; step();
        detect_addr = 1'b0; step();

        // timeout on channel 2, twice
        quiet(); em = 3'b011; steps(2 * TMO + 5);

        // rescue read on the 30th edge, then empty_0 rising at edge 15
        quiet(); em = 3'b110; steps(TMO - 1);
        rd[0] = 1'b1; step();
        rd[0] = 1'b0; steps(14);
        em[0] = 1'b1; step();
        em[0] = 1'b0; steps(TMO + 2);

        // mid-count reset on channel 1
        quiet(); em = 3'b101; steps(20);
        rst = 1'b1; step();
        rst = 1'b0; steps(TMO + 3);

        // randomized phases with varying read/empty activity
        for (int ph = 0; ph < 30; ph++) begin
            p_rd = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 2 : 30);
            p_em = (ph % 2 == 0) ? 1 : 20;
            for (int c = 0; c < 100; c++) begin
                rst           = ($urandom_range(0, 299) == 0);
                detect_addr   = ($urandom_range(0, 7) == 0);
                data_in       = 2'($urandom_range(0, 3));
                write_enb_reg = 1'($urandom);
                fl            = 3'($urandom);
                for (int n = 0; n < 3; n++) begin
                    rd[n] = (int'($urandom_range(0, 99)) < p_rd);
                    em[n] = (int'($urandom_range(0, 99)) < p_em);
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
